// File: rtl/pc_next_seq.sv
// Next-PC sequencer: increment, PC-relative branch, absolute jump, and call/return.
// Define PC_NEXT_SEQ_RAS_EN to build in the return-address stack; otherwise call acts as jump and ret as increment.
module pc_next_seq #(
  parameter logic [10:0] RESET_ADDR = 11'h000,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] read_PC,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_offset,
  input  logic        jump,
  input  logic [10:0] jump_target,
  input  logic        call,
  input  logic        ret,
  output logic [10:0] write_data_PC,
  output logic [2:0]  ras_count,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  logic [10:0] pc_inc;
  logic [10:0] pc_branch;
  logic [10:0] pc_next;

  assign pc_inc    = read_PC + 11'd1;
  assign pc_branch = pc_inc + {{3{branch_offset[7]}}, branch_offset};

`ifdef PC_NEXT_SEQ_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [10:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] ptr_inc;
  logic [2:0]    count;
  logic          ovf_flag;
  logic          udf_flag;
  logic          stack_empty;
  logic          stack_full;
  logic          do_pop;
  logic          do_push;

  // wr_ptr addresses the next free slot; a push at full wraps over the oldest entry
  assign stack_empty = (count == 3'd0);
  assign stack_full  = (count == 3'(RAS_DEPTH));
  assign top_ptr     = (wr_ptr == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr - 1'b1;
  assign ptr_inc     = (wr_ptr == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign do_pop      = ret && !stack_empty;
  assign do_push     = call && !ret;

  always_comb begin
    pc_next = pc_inc;
    if (ret)               pc_next = stack_empty ? pc_inc : ras_mem[top_ptr];
    else if (call)         pc_next = jump_target;
    else if (jump)         pc_next = jump_target;
    else if (branch_taken) pc_next = pc_branch;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      write_data_PC <= RESET_ADDR;
      wr_ptr        <= '0;
      count         <= '0;
      ovf_flag      <= 1'b0;
      udf_flag      <= 1'b0;
    end else if (!stall) begin
      write_data_PC <= pc_next;
      if (do_pop) begin
        wr_ptr <= top_ptr;
        count  <= count - 3'd1;
      end else if (do_push) begin
        wr_ptr <= ptr_inc;
        if (!stack_full) count <= count + 3'd1;
      end
      if (do_push && stack_full)  ovf_flag <= 1'b1;
      if (ret && stack_empty)     udf_flag <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!stall && do_push) ras_mem[wr_ptr] <= pc_inc;
  end

  assign ras_count     = count;
  assign ras_overflow  = ovf_flag;
  assign ras_underflow = udf_flag;
`else
  always_comb begin
    pc_next = pc_inc;
    if (ret)                 pc_next = pc_inc;
    else if (call || jump)   pc_next = jump_target;
    else if (branch_taken)   pc_next = pc_branch;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         write_data_PC <= RESET_ADDR;
    else if (!stall) write_data_PC <= pc_next;
  end

  assign ras_count     = 3'd0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_seq.sv
// Directed self-checking bench for pc_next_seq; expectations follow the PC_NEXT_SEQ_RAS_EN setting of the build.
module tb_pc_next_seq;

  logic        CLK;
  logic        RST;
  logic [10:0] read_PC;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic        jump;
  logic [10:0] jump_target;
  logic        call;
  logic        ret;
  logic [10:0] write_data_PC;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pc_next_seq #(.RESET_ADDR(11'h000), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .read_PC(read_PC), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
    .write_data_PC(write_data_PC), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [10:0] pc, input logic st, input logic br, input logic [7:0] off,
                       input logic jp, input logic [10:0] tgt, input logic cl, input logic rt);
    read_PC = pc; stall = st; branch_taken = br; branch_offset = off;
    jump = jp; jump_target = tgt; call = cl; ret = rt;
  endtask

  // apply one cycle of inputs, then sample just after the active edge
  task automatic cycle(input logic [10:0] pc, input logic st, input logic br, input logic [7:0] off,
                       input logic jp, input logic [10:0] tgt, input logic cl, input logic rt);
    drive(pc, st, br, off, jp, tgt, cl, rt);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b0);
    RST = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("reset_pc", 32'(write_data_PC), 32'h000);
    check("reset_cnt", 32'(ras_count), 32'd0);
    check("reset_ovf", 32'(ras_overflow), 32'd0);
    check("reset_udf", 32'(ras_underflow), 32'd0);
    #9 RST = 1'b0;

    cycle(11'h7FF, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b0);
    check("inc_wrap", 32'(write_data_PC), 32'h000);
    cycle(11'h123, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b0);
    check("inc", 32'(write_data_PC), 32'h124);
    cycle(11'h7FE, 1'b0, 1'b1, 8'h05, 1'b0, 11'h000, 1'b0, 1'b0);
    check("branch_fwd_wrap", 32'(write_data_PC), 32'h004);
    cycle(11'h002, 1'b0, 1'b1, 8'hF0, 1'b0, 11'h000, 1'b0, 1'b0);
    check("branch_back_wrap", 32'(write_data_PC), 32'h7F3);
    cycle(11'h050, 1'b0, 1'b1, 8'h10, 1'b1, 11'h123, 1'b0, 1'b0);
    check("jump_over_branch", 32'(write_data_PC), 32'h123);

`ifdef PC_NEXT_SEQ_RAS_EN
    cycle(11'h010, 1'b0, 1'b0, 8'h00, 1'b0, 11'h200, 1'b1, 1'b0);
    check("call_pc", 32'(write_data_PC), 32'h200);
    check("call_cnt", 32'(ras_count), 32'd1);
    cycle(11'h205, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1);
    check("ret_pc", 32'(write_data_PC), 32'h011);
    check("ret_cnt", 32'(ras_count), 32'd0);

    for (int i = 0; i < 5; i++) begin
      cycle(11'(i), 1'b0, 1'b0, 8'h00, 1'b0, 11'h100, 1'b1, 1'b0);
      if (i == 3) begin
        check("full_cnt", 32'(ras_count), 32'd4);
        check("full_no_ovf", 32'(ras_overflow), 32'd0);
      end
    end
    check("ovf_flag", 32'(ras_overflow), 32'd1);
    check("ovf_cnt", 32'(ras_count), 32'd4);
    check("ovf_pc", 32'(write_data_PC), 32'h100);
    for (int i = 0; i < 4; i++) begin
      cycle(11'h100, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1);
      check("lifo_pop", 32'(write_data_PC), 32'(5 - i));
    end
    check("lifo_no_udf", 32'(ras_underflow), 32'd0);
    cycle(11'h100, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1);
    check("udf_pc", 32'(write_data_PC), 32'h101);
    check("udf_flag", 32'(ras_underflow), 32'd1);
    check("udf_cnt", 32'(ras_count), 32'd0);

    cycle(11'h020, 1'b0, 1'b0, 8'h00, 1'b0, 11'h300, 1'b1, 1'b0);
    check("prio_call_cnt", 32'(ras_count), 32'd1);
    cycle(11'h555, 1'b1, 1'b1, 8'h22, 1'b1, 11'h444, 1'b1, 1'b1);
    check("stall_pc", 32'(write_data_PC), 32'h300);
    check("stall_cnt", 32'(ras_count), 32'd1);
    cycle(11'h300, 1'b0, 1'b0, 8'h00, 1'b1, 11'h444, 1'b1, 1'b1);
    check("ret_wins_pc", 32'(write_data_PC), 32'h021);
    check("ret_wins_cnt", 32'(ras_count), 32'd0);
    cycle(11'h030, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1);
    check("no_push_pc", 32'(write_data_PC), 32'h031);
    check("sticky_ovf", 32'(ras_overflow), 32'd1);
    check("sticky_udf", 32'(ras_underflow), 32'd1);

    cycle(11'h040, 1'b0, 1'b0, 8'h00, 1'b0, 11'h3A0, 1'b1, 1'b0);
    check("pre_rst_cnt", 32'(ras_count), 32'd1);
`else
    cycle(11'h010, 1'b0, 1'b0, 8'h00, 1'b0, 11'h200, 1'b1, 1'b0);
    check("call_pc", 32'(write_data_PC), 32'h200);
    check("call_cnt", 32'(ras_count), 32'd0);
    cycle(11'h205, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1);
    check("ret_pc", 32'(write_data_PC), 32'h206);
    cycle(11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 11'h300, 1'b1, 1'b0);
    check("call_as_jump", 32'(write_data_PC), 32'h300);
    check("call_as_jump_cnt", 32'(ras_count), 32'd0);
    cycle(11'h300, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1);
    check("ret_as_inc", 32'(write_data_PC), 32'h301);
    cycle(11'h300, 1'b0, 1'b1, 8'h10, 1'b0, 11'h000, 1'b0, 1'b1);
    check("ret_over_branch", 32'(write_data_PC), 32'h301);
    cycle(11'h555, 1'b1, 1'b1, 8'h22, 1'b1, 11'h444, 1'b1, 1'b1);
    check("stall_pc", 32'(write_data_PC), 32'h301);
    check("flags_tied_ovf", 32'(ras_overflow), 32'd0);
    check("flags_tied_udf", 32'(ras_underflow), 32'd0);
    cycle(11'h040, 1'b0, 1'b0, 8'h00, 1'b0, 11'h3A0, 1'b1, 1'b0);
`endif
    check("pre_rst_pc", 32'(write_data_PC), 32'h3A0);

    drive(11'h041, 1'b0, 1'b0, 8'h00, 1'b0, 11'h3B0, 1'b1, 1'b0);
    #2 RST = 1'b1;
    #1;
    check("async_rst_pc", 32'(write_data_PC), 32'h000);
    check("async_rst_cnt", 32'(ras_count), 32'd0);
    check("async_rst_ovf", 32'(ras_overflow), 32'd0);
    check("async_rst_udf", 32'(ras_underflow), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    cycle(11'h010, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b0);
    check("post_rst_inc", 32'(write_data_PC), 32'h011);
    cycle(11'h050, 1'b0, 1'b0, 8'h00, 1'b0, 11'h000, 1'b0, 1'b1);
    check("post_rst_ret_empty", 32'(write_data_PC), 32'h051);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
